// File: rtl/sr_latch_bank.sv
// Clocked bank of SR storage cells with defined S=R behaviour, sticky conflict
// flags, a saturating conflict-cycle counter and a new-conflict interrupt pulse.
module sr_latch_bank #(
  parameter int               WIDTH      = 4,
  parameter bit               ACTIVE_LOW = 1'b1,
  parameter int               MODE       = 0,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             conflict_irq
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cf_q, cf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] set_req, rst_req, conf_vec, cf_eff;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    set_req  = ACTIVE_LOW ? ~s : s;
    rst_req  = ACTIVE_LOW ? ~r : r;
    conf_vec = set_req & rst_req;

    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({set_req[i], rst_req[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          // MODE is elaboration-constant, so only one arm survives synthesis
          if (MODE == 0)      q_d[i] = 1'b0;
          else if (MODE == 1) q_d[i] = 1'b1;
          else if (MODE == 2) q_d[i] = q_q[i];
          else                q_d[i] = ~q_q[i];
        end
        default: q_d[i] = q_q[i];
      endcase
    end

    // A clear and a fresh conflict in the same cycle leave the new conflict flagged
    cf_eff   = clr_conflict ? '0 : cf_q;
    cf_d     = cf_eff | conf_vec;

    cnt_base = clr_conflict ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if ((|conf_vec) && !(&cnt_base)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end

    irq_d = |(cf_d & ~cf_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= INIT;
      cf_q  <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cf_q  <= cf_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign q            = q_q;
  assign qbar         = ~q_q;
  assign conflict     = cf_q;
  assign conflict_cnt = cnt_q;
  assign conflict_irq = irq_q;

endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Clocked, parametrised bank of WIDTH independent SR storage cells, replacing free-running cross-coupled latches in the design.
- Selectable input polarity and conflict-resolution mode, so the S=R=asserted case is always defined.
- Per-channel sticky conflict flags, a saturating conflict-cycle counter and a one-cycle interrupt pulse, so control logic can detect and audit illegal stimulus.
- Sits between control decode and status/flag consumers.

Parameters:
- WIDTH, 4: number of SR channels (1..32).
- ACTIVE_LOW, 1: 1 = s/r asserted when 0 (NAND-style); 0 = asserted when 1.
- MODE, 0: conflict resolution; 0 = reset-dominant, 1 = set-dominant, 2 = hold, 3 = toggle.
- INIT, 0: reset value of q (WIDTH bits, bit i for channel i).
- CNT_W, 8: width of the conflict counter.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s  in  WIDTH  per-channel set request, polarity per ACTIVE_LOW.
- r  in  WIDTH  per-channel reset request, polarity per ACTIVE_LOW.
- clr_conflict  in  1  active-high; clears the sticky flags and the counter.
- q  out  WIDTH  stored state.
- qbar  out  WIDTH  always exactly ~q, never equal to q.
- conflict  out  WIDTH  sticky per-channel conflict flags.
- conflict_cnt  out  CNT_W  count of cycles with any conflict, saturating.
- conflict_irq  out  1  one-cycle pulse on a new conflict.

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - q=INIT, qbar=~INIT.
  - conflict=0, conflict_cnt=0, conflict_irq=0.
  - Inputs present in the reset cycle are ignored.
  - Reset mid-operation discards all state.
- Normalisation: S = ACTIVE_LOW ? ~s : s; R likewise. Inputs are sampled at the edge; outputs are registered, so latency is 1 cycle, with no combinational input-to-output path.
- Per channel i, next q:
  - S=0, R=0: hold.
  - S=1, R=0: q=1.
  - S=0, R=1: q=0.
  - S=1, R=1 (conflict): MODE 0 gives 0; MODE 1 gives 1; MODE 2 holds; MODE 3 gives ~q.
- Conflict vector: C = S & R.
- Sticky flags: conflict_next = (clr_conflict ? 0 : conflict) | C. A conflict in the same cycle as a clear remains flagged.
- Counter:
  - Base value = clr_conflict ? 0 : conflict_cnt.
  - If |C, add 1, saturating at 2^CNT_W-1. The counter never wraps.
  - Clear and a conflict in the same cycle gives conflict_cnt = 1.
  - The counter counts cycles, not channels: 3 channels conflicting in one cycle adds 1.
- conflict_irq:
  - Registered; equals 1 for the cycle after any bit of conflict_next & ~conflict_eff is 1, where conflict_eff = clr_conflict ? 0 : conflict.
  - A repeated conflict on an already-flagged channel does not pulse.
  - After a clear, a conflict pulses again.
- Channels are fully independent. There is no interaction between bits except the shared counter and irq.
- Metastability of asynchronous s/r is out of scope; inputs must be synchronous to clk.

Test Plan:
- Reset and default polarity (WIDTH=4, ACTIVE_LOW=1, INIT=4'b0101):
  - Assert rst 2 cycles with s=r=4'b0000 -> q=0101, qbar=1010, conflict=0, cnt=0, irq=0.
  - Release -> q=4'b0101 still (hold, s=r=1111).
- Set/reset/hold, ACTIVE_LOW=1:
  - s=1110, r=1111 -> next cycle q=xxx1 with bit0=1.
  - Then s=1111, r=1101 -> bit1=0.
  - Then s=r=1111 for 3 cycles -> q unchanged.
  - qbar==~q every cycle.
- Conflict modes (run with MODE=0,1,2,3, q=4'b0011, drive s=r=0000 one cycle) -> q = 0000 / 1111 / 0011 / 1100 respectively.
- Sticky flags, counter and irq, ACTIVE_LOW=0, CNT_W=2:
  - Conflict on ch2 -> conflict=0100, cnt=1, irq=1 for one cycle.
  - Ch2 conflicts again -> cnt=2, irq=0.
  - Ch0 conflicts -> conflict=0101, cnt=3, irq=1.
  - 2 further conflict cycles -> cnt stays 3 (saturation).
- Clear interaction:
  - clr_conflict=1 with no conflict -> conflict=0, cnt=0.
  - Next cycle, clr_conflict=1 and ch3 conflicts -> conflict=1000, cnt=1, irq=1.
- Reset mid-operation: with q=1010, conflict=0110, cnt=5, assert rst together with s=r asserted -> q=INIT, conflict=0, cnt=0, irq=0 the next cycle.
